// File: rtl/pc_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: FSM encoding,
// bubble constant, reset PC default and target alignment helper.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-cache read port between the fetch unit (master) and the cache (slave).
interface pc_fetch_unit_if;

  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_readdata,
    input  imem_busywait
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_readdata,
    output imem_busywait
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and an I-cache read
// FSM that parks a redirect arriving during a miss until the read completes.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    branch_jump_signal,
  input  logic [31:0]             branch_target,
  input  logic                    stall,
  pc_fetch_unit_if.master         imem,
  output logic [31:0]             pc_out,
  output logic [31:0]             pc_4_out,
  output logic [31:0]             instruction_out,
  output logic                    busywait
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic [31:0]  pc_plus_4;
  logic [31:0]  aligned_target;

  assign pc_plus_4      = pc_q + 32'd4;
  assign aligned_target = align_target(branch_target);

  assign pc_out   = pc_q;
  assign pc_4_out = pc_plus_4;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_target_q <= NOP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    pend_target_d      = pend_target_q;
    imem.imem_read     = 1'b0;
    imem.imem_address  = pc_q;
    busywait           = 1'b1;
    instruction_out    = NOP;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem.imem_read = 1'b1;
        if (!imem.imem_busywait) begin
          instruction_out = imem.imem_readdata;
          busywait        = stall;
          // A redirect outranks a hazard stall.
          if (branch_jump_signal) begin
            pc_d = aligned_target;
          end else if (!stall) begin
            pc_d = pc_plus_4;
          end
        end else if (branch_jump_signal) begin
          // The outstanding read is allowed to finish; the target waits.
          pend_target_d = aligned_target;
          state_d       = DRAIN;
        end
      end

      DRAIN: begin
        imem.imem_read = 1'b1;
        if (branch_jump_signal) begin
          pend_target_d = aligned_target;
        end
        if (!imem.imem_busywait) begin
          // Returned word belongs to the squashed path and is dropped.
          pc_d    = branch_jump_signal ? aligned_target : pend_target_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle expectations are queued
// as stimulus is driven and compared against the DUT on the falling edge.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        branch_jump_signal;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic [31:0] instruction_out;
  logic        busywait;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic        read;
    logic [31:0] addr;
    logic        busy;
    logic [31:0] instr;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .branch_jump_signal (branch_jump_signal),
    .branch_target      (branch_target),
    .stall              (stall),
    .imem               (bus.master),
    .pc_out             (pc_out),
    .pc_4_out           (pc_4_out),
    .instruction_out    (instruction_out),
    .busywait           (busywait)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hDEAD_BEEF ^ (a * 32'h9E37_79B9);
  endfunction

  // Cache model: returns a word derived from the presented address.
  assign bus.imem_readdata = mem_word(bus.imem_address);

  logic cache_busy;
  assign bus.imem_busywait = cache_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks_total++;
      if (bus.imem_read !== e.read || bus.imem_address !== e.addr ||
          busywait !== e.busy || instruction_out !== e.instr ||
          pc_out !== e.addr || pc_4_out !== e.addr + 32'd4) begin
        $display("FAIL %s: got read=%b addr=%h busy=%b instr=%h pc=%h pc4=%h, want read=%b addr=%h busy=%b instr=%h pc=%h pc4=%h",
                 e.tag, bus.imem_read, bus.imem_address, busywait, instruction_out,
                 pc_out, pc_4_out, e.read, e.addr, e.busy, e.instr, e.addr, e.addr + 32'd4);
      end else begin
        checks_passed++;
      end
    end
  end

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic cycle(input logic bw, input logic br, input logic [31:0] tgt,
                       input logic st, input logic [31:0] exp_addr,
                       input logic exp_busy, input logic hit, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    cache_busy         = bw;
    branch_jump_signal = br;
    branch_target      = tgt;
    stall              = st;
    e.read  = 1'b1;
    e.addr  = exp_addr;
    e.busy  = exp_busy;
    e.instr = hit ? mem_word(exp_addr) : 32'h0;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    cache_busy         = 1'b0;
    branch_jump_signal = 1'b0;
    branch_target      = 32'h0;
    stall              = 1'b0;
  endtask

  // Reset pulse ending after a falling edge; the next rising edge enters FETCH.
  task automatic do_reset();
    @(negedge clk);
    #1;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    idle_inputs();
    reset = 1'b1;
    #2;
    checks_total++;
    if (bus.imem_read !== 1'b0 || busywait !== 1'b1 || instruction_out !== 32'h0 ||
        pc_out !== 32'h0 || pc_4_out !== 32'h4) begin
      $display("FAIL reset_hold: got read=%b busy=%b instr=%h pc=%h pc4=%h, want 0 1 0 0 4",
               bus.imem_read, busywait, instruction_out, pc_out, pc_4_out);
    end else begin
      checks_passed++;
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks_total++;
    if (bus.imem_read !== 1'b0 || busywait !== 1'b1 || instruction_out !== 32'h0) begin
      $display("FAIL boot_state: got read=%b busy=%b instr=%h, want 0 1 0",
               bus.imem_read, busywait, instruction_out);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic test_sequential();
    do_reset();
    cycle(0, 0, 0, 0, 32'h0, 0, 1, "seq_0");
    cycle(0, 0, 0, 0, 32'h4, 0, 1, "seq_4");
    cycle(0, 0, 0, 0, 32'h8, 0, 1, "seq_8");
  endtask

  task automatic test_miss();
    do_reset();
    cycle(0, 0, 0, 0, 32'h0, 0, 1, "miss_pre0");
    cycle(0, 0, 0, 0, 32'h4, 0, 1, "miss_pre4");
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h8, 1, 0, "miss_hold8");
    cycle(0, 0, 0, 0, 32'h8, 0, 1, "miss_deliver8");
    cycle(0, 0, 0, 0, 32'hC, 0, 1, "miss_next12");
  endtask

  task automatic test_stall();
    do_reset();
    cycle(0, 0, 0, 0, 32'h0, 0, 1, "stall_pre0");
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 32'h4, 1, 1, "stall_hold4");
    cycle(0, 0, 0, 0, 32'h4, 0, 1, "stall_release4");
    cycle(0, 0, 0, 0, 32'h8, 0, 1, "stall_next8");
  endtask

  task automatic test_redirect_hit();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 32'(i * 4), 0, 1, "rhit_pre");
    // Redirect together with stall: redirect must still win.
    cycle(0, 1, 32'h0000_0103, 1, 32'h10, 1, 1, "rhit_at16");
    cycle(0, 0, 0, 0, 32'h100, 0, 1, "rhit_target");
    cycle(0, 0, 0, 0, 32'h104, 0, 1, "rhit_next");
  endtask

  task automatic test_redirect_miss();
    do_reset();
    cycle(1, 1, 32'h200, 0, 32'h0, 1, 0, "rmiss_first");
    cycle(1, 1, 32'h300, 0, 32'h0, 1, 0, "rmiss_second");
    cycle(0, 0, 0, 0, 32'h0, 1, 0, "rmiss_discard");
    cycle(0, 0, 0, 0, 32'h300, 0, 1, "rmiss_target");
    cycle(0, 0, 0, 0, 32'h304, 0, 1, "rmiss_next");
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(0, 1, 32'hFFFF_FFFE, 0, 32'h0, 0, 1, "wrap_redirect");
    cycle(0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, "wrap_top");
    cycle(0, 0, 0, 0, 32'h0, 0, 1, "wrap_zero");
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    cycle(0, 0, 0, 0, 32'h0, 0, 1, "rdrain_pre0");
    cycle(0, 0, 0, 0, 32'h4, 0, 1, "rdrain_pre4");
    cycle(1, 1, 32'h200, 0, 32'h8, 1, 0, "rdrain_enter");
    cycle(1, 0, 0, 0, 32'h8, 1, 0, "rdrain_in_drain");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks_total++;
    if (bus.imem_read !== 1'b0 || busywait !== 1'b1 || instruction_out !== 32'h0 ||
        pc_out !== 32'h0) begin
      $display("FAIL reset_mid_drain: got read=%b busy=%b instr=%h pc=%h, want 0 1 0 0",
               bus.imem_read, busywait, instruction_out, pc_out);
    end else begin
      checks_passed++;
    end
    @(negedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
    cycle(0, 0, 0, 0, 32'h0, 0, 1, "rdrain_restart0");
    cycle(0, 0, 0, 0, 32'h4, 0, 1, "rdrain_restart4");
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset         = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);

    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_redirect_hit();
    test_redirect_miss();
    test_wrap();
    test_reset_in_drain();

    @(posedge clk);
    @(posedge clk);
    checks_total++;
    if (sb.size() !== 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end else begin
      checks_passed++;
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
